// File: rtl/pong_frame_renderer.sv
// Raster generator and object renderer for a two-player pong display.
// Positions and scores are latched once per frame at (0, last line), so each visible frame uses one consistent snapshot.
module pong_frame_renderer #(
    parameter int H_VISIBLE      = 800,
    parameter int H_FP           = 40,
    parameter int H_SYNC         = 128,
    parameter int H_BP           = 88,
    parameter int V_VISIBLE      = 600,
    parameter int V_FP           = 1,
    parameter int V_SYNC         = 4,
    parameter int V_BP           = 23,
    parameter int PADDLE_HEIGHT  = 32,
    parameter int PADDLE_DEPTH   = 8,
    parameter int BALL_SIZE      = 4,
    parameter int LEFT_PADDLE_X  = 16,
    parameter int RIGHT_PADDLE_X = 776
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] leftPaddle_y,
    input  logic [9:0] rightPaddle_y,
    input  logic [3:0] iLeft_Score,
    input  logic [3:0] iRight_Score,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [2:0] rgb,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic [10:0] BALL_W     = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_H      = 11'(PADDLE_HEIGHT);
    localparam logic [10:0] LPAD_X     = 11'(LEFT_PADDLE_X);
    localparam logic [10:0] LPAD_X_END = 11'(LEFT_PADDLE_X + PADDLE_DEPTH);
    localparam logic [10:0] RPAD_X     = 11'(RIGHT_PADDLE_X);
    localparam logic [10:0] RPAD_X_END = 11'(RIGHT_PADDLE_X + PADDLE_DEPTH);
    localparam logic [10:0] SCORE_TOP  = 11'd8;
    localparam logic [10:0] SCORE_BOT  = 11'd16;
    localparam logic [10:0] LSCORE_X   = 11'd32;
    localparam logic [10:0] RSCORE_END = 11'(H_VISIBLE - 32);
    localparam logic [10:0] NET_X      = 11'(H_VISIBLE / 2 - 1);
    localparam logic [10:0] NET_X_END  = 11'(H_VISIBLE / 2 + 1);

    // Reset snapshot: ball and paddles centred in the visible area.
    localparam logic [9:0] BALL_X0   = 10'(H_VISIBLE / 2 - BALL_SIZE / 2);
    localparam logic [9:0] BALL_Y0   = 10'(V_VISIBLE / 2 - BALL_SIZE / 2);
    localparam logic [9:0] PADDLE_Y0 = 10'(V_VISIBLE / 2 - PADDLE_HEIGHT / 2);

    logic [10:0] h_cnt, v_cnt;
    logic [9:0]  sh_ball_x, sh_ball_y, sh_left_y, sh_right_y;
    logic [3:0]  sh_left_score, sh_right_score;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sh_ball_x      <= BALL_X0;
            sh_ball_y      <= BALL_Y0;
            sh_left_y      <= PADDLE_Y0;
            sh_right_y     <= PADDLE_Y0;
            sh_left_score  <= '0;
            sh_right_score <= '0;
        end else if (h_cnt == 11'd0 && v_cnt == V_LAST) begin
            sh_ball_x      <= ball_x;
            sh_ball_y      <= ball_y;
            sh_left_y      <= leftPaddle_y;
            sh_right_y     <= rightPaddle_y;
            sh_left_score  <= iLeft_Score;
            sh_right_score <= iRight_Score;
        end
    end

    // All geometry is 11 bits wide so position+size never wraps back onto low coordinates.
    logic [10:0] bx, by, ly, ry, ls_end, rs_width;
    logic        ball_hit, lpad_hit, rpad_hit, lscore_hit, rscore_hit, net_hit;
    logic        score_rows, visible;
    logic [2:0]  rgb_d;

    assign bx       = {1'b0, sh_ball_x};
    assign by       = {1'b0, sh_ball_y};
    assign ly       = {1'b0, sh_left_y};
    assign ry       = {1'b0, sh_right_y};
    assign ls_end   = LSCORE_X + {4'b0, sh_left_score, 3'b000};
    assign rs_width = {4'b0, sh_right_score, 3'b000};

    assign score_rows = (v_cnt >= SCORE_TOP) && (v_cnt < SCORE_BOT);
    assign ball_hit   = (h_cnt >= bx) && (h_cnt < bx + BALL_W) &&
                        (v_cnt >= by) && (v_cnt < by + BALL_W);
    assign lpad_hit   = (h_cnt >= LPAD_X) && (h_cnt < LPAD_X_END) &&
                        (v_cnt >= ly) && (v_cnt < ly + PAD_H);
    assign rpad_hit   = (h_cnt >= RPAD_X) && (h_cnt < RPAD_X_END) &&
                        (v_cnt >= ry) && (v_cnt < ry + PAD_H);
    assign lscore_hit = score_rows && (h_cnt >= LSCORE_X) && (h_cnt < ls_end);
    // Written as h + width >= end so a wide bar never underflows its start column.
    assign rscore_hit = score_rows && (h_cnt < RSCORE_END) && (h_cnt + rs_width >= RSCORE_END);
    assign net_hit    = (h_cnt >= NET_X) && (h_cnt < NET_X_END) && !v_cnt[3];
    assign visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    always_comb begin
        rgb_d = 3'b000;
        if (!visible)                  rgb_d = 3'b000;
        else if (ball_hit)             rgb_d = 3'b111;
        else if (lpad_hit || rpad_hit) rgb_d = 3'b111;
        else if (lscore_hit)           rgb_d = 3'b010;
        else if (rscore_hit)           rgb_d = 3'b100;
        else if (net_hit)              rgb_d = 3'b001;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            video_on   <= 1'b0;
            rgb        <= 3'b000;
            frame_tick <= 1'b0;
        end else begin
            hsync      <= (h_cnt >= HS_START) && (h_cnt < HS_END);
            vsync      <= (v_cnt >= VS_START) && (v_cnt < VS_END);
            video_on   <= visible;
            rgb        <= rgb_d;
            frame_tick <= (h_cnt == 11'd0) && (v_cnt == V_VIS);
        end
    end

endmodule

// File: doc/pong_frame_renderer.md
PONG_FRAME_RENDERER -- requirements
Module: pong_frame_renderer

Interface
REQ-001 SHALL have parameters: H_VISIBLE 800, H_FP 40, H_SYNC 128, H_BP 88, V_VISIBLE 600, V_FP 1, V_SYNC 4, V_BP 23, the standard 800x600@60 timing at a 40 MHz pixel clock.
REQ-002 SHALL have parameters: PADDLE_HEIGHT 32, PADDLE_DEPTH 8, BALL_SIZE 4, LEFT_PADDLE_X 16, RIGHT_PADDLE_X 776 (paddle column start positions).
REQ-003 clock  in  1  pixel clock; the only clock.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 ball_x, ball_y, leftPaddle_y, rightPaddle_y  in  10 each  object top-left positions driven by the game controller.
REQ-006 iLeft_Score, iRight_Score  in  4 each  current scores.
REQ-007 hsync, vsync  out  1 each  active-high sync outputs.
REQ-008 video_on  out  1  high when the pixel is in the visible area.
REQ-009 rgb  out  3  pixel colour as {r,g,b}.
REQ-010 frame_tick  out  1  one-cycle pulse per frame; drives the controller's enable input.

Function
REQ-011 h_cnt SHALL count 0..1055 and wrap to 0; at wrap, v_cnt SHALL increment and wrap 627->0.
REQ-012 Visible area SHALL be h_cnt<800 and v_cnt<600.
REQ-013 Sync pulses SHALL assert for 840<=h_cnt<968 (hsync) and 601<=v_cnt<605 (vsync).
REQ-014 hsync, vsync, video_on, rgb and frame_tick SHALL all be registered with exactly 1 cycle of latency from the counter values that produce them, so all five are mutually aligned.
REQ-015 The frame_tick pulse SHALL be generated from h_cnt==0 and v_cnt==600, giving one pulse per 1056*628 cycles.
REQ-016 Shadow registers SHALL capture all six position/score inputs on the cycle where h_cnt==0 and v_cnt==627.
- Drawing SHALL use only the shadow values, so every visible frame is tear-free.
REQ-017 Object hit tests on the current (h,v) position, all with half-open ranges:
- ball: x in [bx,bx+4), y in [by,by+4).
- left paddle: x in [16,24), y in [ly,ly+32).
- right paddle: x in [776,784), y in [ry,ry+32).
- left score bar: x in [32,32+8*ls), y in [8,16).
- right score bar: x in [768-8*rs,768), y in [8,16).
- net: x in [399,401) and v_cnt[3]==0.
REQ-018 All hit-test comparisons SHALL be at least 11 bits wide, so that bx+4 and ly+32 near 1023 do not wrap and produce false hits at low coordinates.
REQ-019 A score of 0 SHALL draw no bar; a score of 15 SHALL draw a 120-pixel bar.
REQ-020 Colour priority SHALL be: ball 3'b111 > paddles 3'b111 > left score 3'b010 > right score 3'b100 > net 3'b001 > background 3'b000.
REQ-021 Outside the visible area, rgb SHALL be 3'b000 regardless of any hit.
REQ-022 Objects whose positions extend past the visible area SHALL be clipped by REQ-021; no other clamping is applied.
REQ-023 Input changes between latch points SHALL have no effect on rgb until after the next latch.

Reset
REQ-024 While resetn is low, outputs SHALL hold these values, asynchronously: h_cnt=0, v_cnt=0, hsync=0, vsync=0, video_on=0, rgb=0, frame_tick=0.
REQ-025 Reset SHALL set the shadow registers to ball (398,298), paddles 284, scores 0.
REQ-026 The first rising edge after resetn deasserts SHALL begin counting from (0,0); the first pixel output (0,0) appears on the following cycle.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no partial frame_tick.

Verification
REQ-028 Timing: reset, then run 2 frames -> hsync period 1056 with high width 128; vsync period 663168 with high width 4224; frame_tick exactly once per frame, 1 cycle wide.
REQ-029 Default frame after reset -> rgb 3'b111 at pixels (398..401, 298..301), (16..23, 284..315) and (776..783, 284..315); 3'b001 at (399,0); 3'b000 at (0,0).
REQ-030 Scores ls=3, rs=15, latched at the next frame -> green for x 32..55, y 8..15; red for x 648..767; the pixel at x=56 is not green.
REQ-031 Tear check: change ball_x from 398 to 100 at v_cnt=300 -> the remainder of that frame still draws the ball at 398; the next frame draws it at 100.
REQ-032 Wrap edge: ly=1020 -> no left-paddle pixels at y 0..27 (11-bit compare); priority check with the ball at (16,290) over the paddle -> rgb 3'b111 with no glitch.
REQ-033 Async reset: drop resetn at h_cnt=500, v_cnt=200 -> all outputs go to 0 without waiting for a clock edge; release -> timing restarts at (0,0).
